// File: rtl/data_mem_ctrl.sv
// Byte-addressable 32-bit data memory with a req/ready handshake and an
// optional wait-state delay. Supports byte/half/word loads and stores with
// little-endian lane select, and range/size error reporting.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned half/word -> err).
module data_mem_ctrl #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       capture;
  logic       enter_resp;

  // Captured request fields
  logic        we_q;
  logic [1:0]  size_q;
  logic        sx_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Effective request: live inputs in IDLE (zero-wait commit), captured otherwise
  logic        a_we;
  logic [1:0]  a_size;
  logic        a_sx;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic              out_of_range;
  logic              size_bad;
  logic              misalign;
  logic              fault;
  logic [1:0]        lane;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_sh;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_val;
  logic [31:0]       resp_data;

  logic        ready_q;
  logic        err_q;
  logic [31:0] r_data_q;

  // Select which copy of the request the datapath works from
  always_comb begin
    if (state_q == StIdle) begin
      a_we    = we;
      a_size  = size;
      a_sx    = sign_ext;
      a_addr  = addr;
      a_wdata = w_data;
    end else begin
      a_we    = we_q;
      a_size  = size_q;
      a_sx    = sx_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
  end

  // Address decode, fault detection and lane selection
  always_comb begin
    word_idx     = a_addr[ADDR_W+1:2];
    out_of_range = |a_addr[31:ADDR_W+2];
    size_bad     = (a_size == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((a_size == 2'b01) && a_addr[0]) ||
               ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    fault = out_of_range | size_bad | misalign;

    lane    = 2'b00;
    byte_en = 4'b0000;
    unique case (a_size)
      2'b00: begin
        lane    = a_addr[1:0];
        byte_en = 4'b0001 << a_addr[1:0];
      end
      2'b01: begin
        lane    = {a_addr[1], 1'b0};
        byte_en = a_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        lane    = 2'b00;
        byte_en = 4'b1111;
      end
      default: begin
        lane    = 2'b00;
        byte_en = 4'b0000;
      end
    endcase
    wdata_sh = a_wdata << {lane, 3'b000};
  end

  // Load path: pick the lane from the addressed word and extend it
  always_comb begin
    rd_word = mem_q[word_idx];
    unique case (lane)
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (a_size)
      2'b00:   load_val = {{24{a_sx & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{a_sx & rd_half[15]}}, rd_half};
      2'b10:   load_val = rd_word;
      default: load_val = 32'h0;
    endcase
    resp_data = (a_we || fault) ? 32'h0 : load_val;
  end

  // FSM next state; enter_resp marks the commit edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sx_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (capture) begin
      we_q    <= we;
      size_q  <= size;
      sx_q    <= sign_ext;
      addr_q  <= addr;
      wdata_q <= w_data;
    end
  end

  // Storage array; cleared on reset, written only on the commit edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (enter_resp && a_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  // Response registers: non-zero only during the ready cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      r_data_q <= 32'h0;
    end else begin
      ready_q  <= enter_resp;
      err_q    <= enter_resp & fault;
      r_data_q <= enter_resp ? resp_data : 32'h0;
    end
  end

  assign ready  = ready_q;
  assign err    = err_q;
  assign r_data = r_data_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: two instances (zero-wait and
// three-wait), directed scenarios plus randomized traffic checked against
// a byte-array reference model. Honours DMEM_MISALIGN_TRAP_EN.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_s   [2];
  logic        req_s   [2];
  logic        we_s    [2];
  logic [1:0]  size_s  [2];
  logic        sx_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wd_s    [2];
  logic [31:0] rd_s    [2];
  logic        rdy_s   [2];
  logic        busy_s  [2];
  logic        err_s   [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: byte image of each instance's memory (512 bytes)
  logic [7:0] mm [2][512];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_mem_ctrl #(
      .ADDR_W      (7),
      .WAIT_CYCLES ((g == 0) ? 0 : 3)
    ) u_dut (
      .clk      (clk),
      .reset    (rst_s[g]),
      .req      (req_s[g]),
      .we       (we_s[g]),
      .size     (size_s[g]),
      .sign_ext (sx_s[g]),
      .addr     (addr_s[g]),
      .w_data   (wd_s[g]),
      .r_data   (rd_s[g]),
      .ready    (rdy_s[g]),
      .busy     (busy_s[g]),
      .err      (err_s[g])
    );
  end

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_clear(input int d);
    for (int i = 0; i < 512; i++) mm[d][i] = 8'h00;
  endfunction

  // Behavioural access: returns expected r_data/err and applies stores
  function automatic void model_access(input int d, input logic w, input logic [1:0] sz,
                                       input logic sx, input logic [31:0] a,
                                       input logic [31:0] wd, output logic [31:0] rd,
                                       output logic e);
    int base;
    int nb;
    logic [31:0] v;
    rd = 32'h0;
    e  = 1'b0;
    if (a >= 32'd512 || sz == 2'b11) e = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) e = 1'b1;
`endif
    if (e) return;
    nb   = 1 << sz;
    base = int'(a) & ~(nb - 1);
    if (w) begin
      for (int i = 0; i < nb; i++) mm[d][base + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(mm[d][base + i]) << (8 * i));
      if (sx && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
      if (sx && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endfunction

  // One full transaction with latency/busy/strobe checks against the model.
  // poke=1 issues an extra store request while the instance is busy.
  task automatic access(input int d, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input bit poke,
                        output logic [31:0] rd, output logic e);
    logic [31:0] xrd;
    logic        xe;
    int          lat;
    int          k;
    bit          seen;
    lat = (d == 0) ? 0 : 3;
    model_access(d, w, sz, sx, a, wd, xrd, xe);
    @(negedge clk);
    req_s[d]  = 1'b1;
    we_s[d]   = w;
    size_s[d] = sz;
    sx_s[d]   = sx;
    addr_s[d] = a;
    wd_s[d]   = wd;
    @(posedge clk);
    #1 req_s[d] = 1'b0;
    seen = 1'b0;
    k    = 0;
    while (!seen && k <= lat + 4) begin
      @(negedge clk);
      req_s[d] = 1'b0;
      if (rdy_s[d]) begin
        seen = 1'b1;
      end else begin
        check_eq("busy_wait", 32'(busy_s[d]), 32'd1);
        if (poke && k == 1) begin
          req_s[d]  = 1'b1;
          we_s[d]   = 1'b1;
          size_s[d] = 2'b10;
          addr_s[d] = 32'h40;
          wd_s[d]   = 32'hFFFF_FFFF;
        end
        k++;
      end
    end
    check_eq("ready_seen", 32'(seen), 32'd1);
    check_eq("latency", 32'(k), 32'(lat));
    check_eq("busy_resp", 32'(busy_s[d]), 32'd1);
    rd = rd_s[d];
    e  = err_s[d];
    check_eq("r_data", rd, xrd);
    check_eq("err", 32'(e), 32'(xe));
    @(negedge clk);
    check_eq("ready_drop", 32'(rdy_s[d]), 32'd0);
    check_eq("r_data_idle", rd_s[d], 32'h0);
    check_eq("err_idle", 32'(err_s[d]), 32'd0);
    check_eq("busy_idle", 32'(busy_s[d]), 32'd0);
  endtask

  // Count ready pulses over n cycles
  task automatic count_ready(input int d, input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rdy_s[d]) pulses++;
    end
  endtask

  logic [31:0] rd;
  logic        e;
  int          pulses;

  initial begin
    clk = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rst_s[d]  = 1'b1;
      req_s[d]  = 1'b0;
      we_s[d]   = 1'b0;
      size_s[d] = 2'b00;
      sx_s[d]   = 1'b0;
      addr_s[d] = 32'h0;
      wd_s[d]   = 32'h0;
      model_clear(d);
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("reset_ready", 32'(rdy_s[d]), 32'd0);
      check_eq("reset_busy", 32'(busy_s[d]), 32'd0);
      check_eq("reset_err", 32'(err_s[d]), 32'd0);
      check_eq("reset_r_data", rd_s[d], 32'h0);
      rst_s[d] = 1'b0;
    end

    // Zero-wait instance: directed loads/stores
    access(0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, rd, e);
    check_eq("lw0_data", rd, 32'h0);
    check_eq("lw0_err", 32'(e), 32'd0);
    access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd, e);
    access(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, rd, e);
    check_eq("lb_13", rd, 32'hFFFFFFDE);
    access(0, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, rd, e);
    check_eq("lbu_12", rd, 32'h000000AD);
    access(0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, rd, e);
    check_eq("lh_10", rd, 32'hFFFFBEEF);
    access(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h55, 1'b0, rd, e);
    access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd, e);
    check_eq("lw_after_sb", rd, 32'hDEAD55EF);
    access(0, 1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678, 1'b0, rd, e);
    check_eq("oor_err", 32'(e), 32'd1);
    access(0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, rd, e);
    check_eq("oor_no_write", rd, 32'h0);
    access(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, rd, e);
    check_eq("size_err", 32'(e), 32'd1);
    access(0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b0, rd, e);
`ifdef DMEM_MISALIGN_TRAP_EN
    check_eq("lw_mis_err", 32'(e), 32'd1);
    check_eq("lw_mis_data", rd, 32'h0);
`else
    check_eq("lw_mis_err", 32'(e), 32'd0);
    check_eq("lw_mis_data", rd, 32'hDEAD55EF);
`endif

    // Three-wait instance: latency, ignored request while busy
    access(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 1'b0, rd, e);
    access(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, rd, e);
    count_ready(1, 6, pulses);
    check_eq("busy_req_ignored", 32'(pulses), 32'd0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, rd, e);
    check_eq("poke_no_write", rd, 32'h12345678);

    // Reset while a store is waiting
    @(negedge clk);
    req_s[1]  = 1'b1;
    we_s[1]   = 1'b1;
    size_s[1] = 2'b10;
    addr_s[1] = 32'h20;
    wd_s[1]   = 32'hAABBCCDD;
    @(posedge clk);
    #1 req_s[1] = 1'b0;
    @(negedge clk);
    check_eq("mid_busy", 32'(busy_s[1]), 32'd1);
    rst_s[1] = 1'b1;
    model_clear(1);
    @(negedge clk);
    check_eq("mid_rst_busy", 32'(busy_s[1]), 32'd0);
    rst_s[1] = 1'b0;
    count_ready(1, 6, pulses);
    check_eq("mid_rst_no_ready", 32'(pulses), 32'd0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, rd, e);
    check_eq("mid_rst_no_write", rd, 32'h0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, rd, e);
    check_eq("rst_clears_mem", rd, 32'h0);

    // Randomized traffic on both instances
    for (int i = 0; i < 200; i++) begin
      int          d;
      logic [31:0] a;
      d = i % 2;
      if ($urandom_range(0, 9) == 0) a = 32'h200 + $urandom_range(0, 32'hFFFF);
      else a = 32'($urandom_range(0, 63));
      access(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom(), 1'b0, rd, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
